// File: rtl/dlatch_bank_write_ctrl.sv
// rtl/dlatch_bank_write_ctrl.sv - two-requester round-robin write sequencer for an external D-latch bank
module dlatch_bank_write_ctrl #(
    parameter int WIDTH     = 8,
    parameter int NREG      = 4,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             req0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic [NREG-1:0]  G,
    output logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             gnt
);

    localparam int CW = 16;
    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_ACK
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_d;
    logic [NREG-1:0]  r_g;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err;
    logic             r_err_flag;
    logic             r_busy;
    logic             r_gnt;

    logic             w_any_req;
    logic             w_win;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic             w_bad_addr;
    logic [NREG-1:0]  w_onehot;

    // Winner selection: a lone request wins outright, a tie goes to the requester not granted last time
    always_comb begin
        w_any_req  = req0 | req1;
        w_win      = (req0 && req1) ? ~r_gnt : req1;
        w_addr     = w_win ? addr1 : addr0;
        w_data     = w_win ? data1 : data0;
        w_bad_addr = ({1'b0, r_addr} >= NREG_W);
        w_onehot   = w_bad_addr ? '0 : (NREG'(1) << r_addr);
    end

    // Write sequencing FSM; every output is a register updated on state entry so D and G never move together
    always_ff @(posedge C) begin
        if (R) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_d        <= '0;
            r_g        <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
            r_busy     <= 1'b0;
            r_gnt      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt      <= w_win;
                        r_addr     <= w_addr;
                        r_d        <= w_data;
                        r_err_flag <= 1'b0;
                        r_busy     <= 1'b1;
                        r_cnt      <= CW'(SETUP_CYC - 1);
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_g        <= w_onehot;
                        r_err_flag <= w_bad_addr;
                        r_cnt      <= CW'(PULSE_CYC - 1);
                        r_state    <= ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_g     <= '0;
                        r_cnt   <= CW'(HOLD_CYC - 1);
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                        r_err   <= r_err_flag;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    // D is left alone here so the latch data stays put until the next grant
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_g     <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign err  = r_err;
    assign G    = r_g;
    assign D    = r_d;
    assign busy = r_busy;
    assign gnt  = r_gnt;

endmodule

// File: tb/tb_dlatch_bank_write_ctrl.sv
// tb/tb_dlatch_bank_write_ctrl.sv - randomized and directed bench for dlatch_bank_write_ctrl
module tb_dlatch_bank_write_ctrl;

    localparam int WIDTH = 8;
    localparam int NREG  = 4;
    localparam int AW    = 3;
    localparam int S     = 1;
    localparam int P     = 2;
    localparam int H     = 1;
    localparam int LAT   = S + P + H + 1;
    localparam int VW    = 3 + NREG + WIDTH + 2;

    logic             C = 1'b0;
    logic             R = 1'b1;
    logic             req0 = 1'b0;
    logic [AW-1:0]    addr0 = '0;
    logic [WIDTH-1:0] data0 = '0;
    logic             req1 = 1'b0;
    logic [AW-1:0]    addr1 = '0;
    logic [WIDTH-1:0] data1 = '0;
    logic             ack0, ack1, err, busy, gnt;
    logic [NREG-1:0]  G;
    logic [WIDTH-1:0] D;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: one transaction described by its grant time offset
    bit               m_active;
    int               m_off;
    int               m_addr;
    logic [WIDTH-1:0] m_d;
    bit               m_gnt;

    logic [VW-1:0]    exp_vec;
    logic [VW-1:0]    dut_vec;
    logic [WIDTH-1:0] prev_d;
    logic [NREG-1:0]  prev_g;

    dlatch_bank_write_ctrl #(
        .WIDTH(WIDTH), .NREG(NREG), .AW(AW),
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .C(C), .R(R),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .err(err),
        .G(G), .D(D), .busy(busy), .gnt(gnt)
    );

    always #5 C = ~C;

    // Advance one clock edge and update the model with the inputs that edge sampled
    task automatic tick();
        bit               w;
        logic [NREG-1:0]  eg;
        bit               eack;
        prev_d = D;
        prev_g = G;
        @(posedge C);
        if (R) begin
            m_active = 0; m_off = 0; m_d = '0; m_gnt = 1;
        end else if (m_active) begin
            if (m_off == LAT) m_active = 0;
            else m_off++;
        end else if (req0 || req1) begin
            w = (req0 && req1) ? !m_gnt : req1;
            m_gnt    = w;
            m_addr   = w ? int'(addr1) : int'(addr0);
            m_d      = w ? data1 : data0;
            m_active = 1;
            m_off    = 1;
        end
        #1;
        eg = '0;
        if (m_active && m_off > S && m_off <= S + P && m_addr < NREG) eg[m_addr] = 1'b1;
        eack = m_active && (m_off == LAT);
        exp_vec = {eack && !m_gnt, eack && m_gnt, eack && (m_addr >= NREG),
                   eg, m_d, m_active, m_gnt};
        dut_vec = {ack0, ack1, err, G, D, busy, gnt};
    endtask

    task automatic do_reset();
        R = 1'b1; req0 = 0; req1 = 0;
        tick(); tick();
        R = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== {3'b000, {NREG{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b1})
            $display("FAIL reset_values got=%h want=%h", dut_vec, {3'b000, {NREG{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_single_write();
        req0 = 1; addr0 = 3'd2; data0 = 8'hA5;
        tick();
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (dut_vec !== exp_vec) $display("FAIL single_model c=%0d got=%h want=%h", c, dut_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (D !== 8'hA5) $display("FAIL single_d c=%0d got=%h want=a5", c, D);
            else n_pass++;
            n_checks++;
            if (G !== ((c == 2 || c == 3) ? 4'b0100 : 4'b0000))
                $display("FAIL single_g c=%0d got=%b want=%b", c, G, (c == 2 || c == 3) ? 4'b0100 : 4'b0000);
            else n_pass++;
            n_checks++;
            if ({ack0, err} !== ((c == 5) ? 2'b10 : 2'b00))
                $display("FAIL single_ack c=%0d got=%b want=%b", c, {ack0, err}, (c == 5) ? 2'b10 : 2'b00);
            else n_pass++;
            if (c == 5) req0 = 0;
            tick();
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        R = 1'b1;
        req0 = 1; addr0 = 3'd0; data0 = 8'd11;
        req1 = 1; addr1 = 3'd3; data1 = 8'd22;
        tick();
        R = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) $display("FAIL rr_model c=%0d got=%h want=%h", c, dut_vec, exp_vec);
            else n_pass++;
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            if (G == 4'b0001 && D !== 8'd11) begin
                n_checks++;
                $display("FAIL rr_data0 got=%0d want=11", D);
            end
            if (G == 4'b1000) begin
                n_checks++;
                if (D !== 8'd22) $display("FAIL rr_data1 got=%0d want=22", D);
                else n_pass++;
            end
        end
        n_checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0)
            $display("FAIL rr_order got_n=%0d want=3 (0,1,0)", order.size());
        else n_pass++;
        do_reset();
    endtask

    task automatic test_bad_addr();
        req1 = 1; addr1 = 3'd5; data1 = 8'h77;
        tick();
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (dut_vec !== exp_vec) $display("FAIL bad_model c=%0d got=%h want=%h", c, dut_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if (G !== 4'b0000) $display("FAIL bad_g c=%0d got=%b want=0000", c, G);
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if ({ack1, err} !== 2'b11) $display("FAIL bad_ack got=%b want=11", {ack1, err});
                else n_pass++;
                req1 = 0;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1; addr0 = 3'd1; data0 = 8'h5A;
        tick(); tick();
        n_checks++;
        if (G !== 4'b0010) $display("FAIL midrst_pre_g got=%b want=0010", G);
        else n_pass++;
        R = 1; req0 = 0;
        tick();
        R = 0;
        n_checks++;
        if ({G, D, busy} !== {4'b0000, 8'h00, 1'b0})
            $display("FAIL midrst_clear got=%h want=%h", {G, D, busy}, {4'b0000, 8'h00, 1'b0});
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if ({ack0, ack1} !== 2'b00 || dut_vec !== exp_vec)
                $display("FAIL midrst_noack c=%0d got=%h want=%h", c, dut_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_data_change();
        req0 = 1; addr0 = 3'd3; data0 = 8'hA5;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin data0 = 8'h3C; addr0 = 3'd0; end
            n_checks++;
            if (D !== 8'hA5 || dut_vec !== exp_vec)
                $display("FAIL datachg c=%0d got=%h want=%h", c, dut_vec, exp_vec);
            else n_pass++;
            if (c == 5) req0 = 0;
            tick();
        end
    endtask

    task automatic test_random();
        bool_t_dummy();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(199) == 0) R = 1; else R = 0;
            if (req0 && ack0) req0 = 0;
            else if (!req0 && $urandom_range(2) == 0) begin
                req0 = 1; addr0 = AW'($urandom); data0 = WIDTH'($urandom);
            end else if (req0 && $urandom_range(7) == 0) data0 = WIDTH'($urandom);
            if (req1 && ack1) req1 = 0;
            else if (!req1 && $urandom_range(2) == 0) begin
                req1 = 1; addr1 = AW'($urandom); data1 = WIDTH'($urandom);
            end else if (req1 && $urandom_range(7) == 0) addr1 = AW'($urandom);
            tick();
            n_checks++;
            if (dut_vec !== exp_vec) $display("FAIL rand_model c=%0d got=%h want=%h", c, dut_vec, exp_vec);
            else n_pass++;
            n_checks++;
            if ((G != '0 && D !== prev_d) || $countones(G) > 1)
                $display("FAIL rand_invariant c=%0d got_g=%b d=%h prev_d=%h want=stable_onehot", c, G, D, prev_d);
            else n_pass++;
        end
        R = 0; req0 = 0; req1 = 0;
    endtask

    function automatic void bool_t_dummy();
        prev_g = '0;
    endfunction

    initial begin
        m_active = 0; m_off = 0; m_addr = 0; m_d = '0; m_gnt = 1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_bad_addr();
        test_reset_mid();
        test_data_change();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dlatch_bank_write_ctrl.md
Name: dlatch_bank_write_ctrl

Overview:
Sequences writes into a bank of NREG level-sensitive D-latch registers, each WIDTH bits, that are shared between two requesters. It arbitrates round-robin and drives the shared data bus D. It also generates a one-hot gate pulse on G so that D is stable before, during and after the gate window. The latches sit outside this block and take G[i] as their C input and D as their D input.

Parameters:
WIDTH, 8, data width of each latch register and of the D bus
NREG, 4, number of latch registers in the bank
AW, 2, address width; must be at least clog2(NREG)
SETUP_CYC, 1, cycles D is driven with all gates low before the pulse (>=1)
PULSE_CYC, 2, cycles the selected gate is held high (>=1)
HOLD_CYC, 1, cycles D is held after the gate falls (>=1)

Ports:
C  in  1  clock, rising-edge active
R  in  1  synchronous active-high reset
req0  in  1  write request, requester 0
addr0  in  AW  target register, requester 0
data0  in  WIDTH  write data, requester 0
req1  in  1  write request, requester 1
addr1  in  AW  target register, requester 1
data1  in  WIDTH  write data, requester 1
ack0  out  1  one-cycle completion pulse, requester 0
ack1  out  1  one-cycle completion pulse, requester 1
err  out  1  valid with ack; set when the address was >= NREG
G  out  NREG  one-hot latch gate enables
D  out  WIDTH  shared latch data bus
busy  out  1  high whenever the FSM is not in IDLE
gnt  out  1  index of the current or last granted requester

Behaviour:
- Clocking: one clock C; reset R is synchronous and active-high. All outputs are registered.
- Reset values: ack0=ack1=err=0, G=0, D=0, busy=0, gnt=1. The round-robin pointer is reset to 1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, PULSE, HOLD, ACK. A down-counter is loaded at each state entry.
- IDLE:
  - If any req is high at an edge, grant: only one high wins; both high goes to the requester other than gnt.
  - At that same edge: capture addr/data of the winner, load D=data, update gnt, go to SETUP.
  - Requests that arrive in a later cycle are not granted in the same cycle.
- SETUP: lasts SETUP_CYC cycles; G=0 and D stable.
- PULSE: lasts PULSE_CYC cycles; G[addr]=1 and all other bits 0. If addr >= NREG, G stays 0 and an error flag is latched.
- HOLD: lasts HOLD_CYC cycles; G=0 and D unchanged.
- ACK: one cycle; ack of the granted requester is 1 and err reflects the flag. The next state is always IDLE; D keeps its value until the next grant.
- Guarantee: G is never high in the same cycle that D changes, and at most one G bit is high at any time.
- Latency: req sampled at edge k gives ack high in cycle k+SETUP_CYC+PULSE_CYC+HOLD_CYC+1. With defaults that is 5 cycles. Back-to-back throughput is one write per 6 cycles.
- Requester contract:
  - Hold req until ack and drop it the cycle after ack.
  - addr/data are sampled only at grant; later changes are ignored.
  - A req still high in the cycle after ACK is treated as a new request.
- Request withdrawn mid-operation: the write still completes and ack is still issued.
- Reset mid-operation: at the next edge G goes to 0, D goes to 0, state goes to IDLE, and no ack is produced for the aborted write.

Test Plan:
1. Reset, then req0=1, addr0=2, data0=8'hA5 -> D=A5 from cycle 1; G=4'b0100 in cycles 2-3 only; G=0 in cycle 4; ack0=1, err=0 in cycle 5.
2. req0 and req1 both high from reset (addr0=0, data0=11, addr1=3, data1=22) -> requester 0 is served first (G=0001, ack0), then requester 1 (G=1000, ack1). Toggling continues while both are held.
3. req1 with addr1=5 and NREG=4 -> G stays 0 throughout; ack1=1 and err=1 in cycle 5.
4. Assert R in cycle 2 of a write (G high) -> G=0 and D=0 at the next edge; busy=0; no ack pulse.
5. Change data0 from A5 to 3C in cycle 2 after grant -> D stays A5 through HOLD.
6. Sweep the checker across all cycles: D never changes while any G bit is high, and popcount(G) is at most 1.
